// File: rtl/branch_pkg.sv
// branch_pkg: shared branch-mode and BHT encodings plus BHT index-width helper.
package branch_pkg;
    typedef enum logic [2:0] {BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ} br_mode_e;
    typedef enum logic [1:0] {SNT, WNT, WT, ST} bht_state_e;
    function automatic int unsigned idx_w(int unsigned depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: IF lookup, EX resolve inputs and registered resolve outputs.
interface branch_resolve_unit_if #(parameter int WIDTH = 32, parameter int CNT_W = 16);
    logic [WIDTH-1:0] if_pc;
    logic             if_pred_taken;
    logic             ex_valid;
    logic             ex_stall;
    logic             ex_is_branch;
    logic [2:0]       ex_br_mode;
    logic [WIDTH-1:0] ex_rs;
    logic [WIDTH-1:0] ex_rt;
    logic [WIDTH-1:0] ex_pc;
    logic [WIDTH-1:0] ex_target;
    logic             ex_pred_taken;
    logic             res_valid;
    logic             res_taken;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;
    modport master (
        output if_pc, ex_valid, ex_stall, ex_is_branch, ex_br_mode, ex_rs, ex_rt, ex_pc,
               ex_target, ex_pred_taken,
        input  if_pred_taken, res_valid, res_taken, redirect, redirect_pc, br_count, mispred_count
    );
    modport slave (
        input  if_pc, ex_valid, ex_stall, ex_is_branch, ex_br_mode, ex_rs, ex_rt, ex_pc,
               ex_target, ex_pred_taken,
        output if_pred_taken, res_valid, res_taken, redirect, redirect_pc, br_count, mispred_count
    );
endinterface

// File: rtl/bht_table.sv
// bht_table: array of 2-bit saturating counters, async read port, sync update, reset to weak-not-taken.
module bht_table
    import branch_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IW    = idx_w(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] rd_idx,
    output logic [1:0]    rd_ctr,
    input  logic          upd_en,
    input  logic [IW-1:0] upd_idx,
    input  logic          upd_taken
);
    logic [1:0] ctr_q [DEPTH];
    logic [1:0] cur;
    logic [1:0] ctr_d;

    // Read returns the stored value; a same-cycle update is not bypassed.
    assign rd_ctr = ctr_q[rd_idx];

    always_comb begin
        cur   = ctr_q[upd_idx];
        ctr_d = upd_taken ? (cur == ST ? cur : cur + 2'd1) : (cur == SNT ? cur : cur - 2'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ctr_q[i] <= WNT;
        end else if (upd_en) begin
            ctr_q[upd_idx] <= ctr_d;
        end
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves EX conditional branches, registers outcome/redirect, trains the BHT, keeps stats.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 16
) (
    input logic                 clk,
    input logic                 reset,
    branch_resolve_unit_if.slave bus
);
    localparam int IW = idx_w(BHT_DEPTH);

    logic             taken;
    logic             resolve;
    logic             mispred;
    logic [1:0]       pred_ctr;
    logic             res_valid_q, res_valid_d;
    logic             res_taken_q, res_taken_d;
    logic             redirect_q, redirect_d;
    logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    bht_table #(.DEPTH(BHT_DEPTH)) u_bht (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (bus.if_pc[IW+1:2]),
        .rd_ctr    (pred_ctr),
        .upd_en    (resolve),
        .upd_idx   (bus.ex_pc[IW+1:2]),
        .upd_taken (taken)
    );

    // Signed modes only look at rs; reserved modes fall through to not-taken.
    always_comb begin
        taken = bus.ex_br_mode == BR_BEQ  ? bus.ex_rs == bus.ex_rt :
                bus.ex_br_mode == BR_BNE  ? bus.ex_rs != bus.ex_rt :
                bus.ex_br_mode == BR_BLEZ ? ($signed(bus.ex_rs) <= $signed(WIDTH'(0))) :
                bus.ex_br_mode == BR_BGTZ ? ($signed(bus.ex_rs) >  $signed(WIDTH'(0))) :
                bus.ex_br_mode == BR_BLTZ ? bus.ex_rs[WIDTH-1] :
                bus.ex_br_mode == BR_BGEZ ? ~bus.ex_rs[WIDTH-1] : 1'b0;
        resolve = bus.ex_valid & ~bus.ex_stall & bus.ex_is_branch & (bus.ex_br_mode <= BR_BGEZ);
        mispred = resolve & (taken != bus.ex_pred_taken);
    end

    always_comb begin
        res_valid_d   = resolve;
        res_taken_d   = resolve & taken;
        redirect_d    = mispred;
        redirect_pc_d = !resolve ? redirect_pc_q : taken ? bus.ex_target : bus.ex_pc + WIDTH'(4);
        br_cnt_d      = br_cnt_q + CNT_W'(resolve && br_cnt_q != '1);
        mis_cnt_d     = mis_cnt_q + CNT_W'(mispred && mis_cnt_q != '1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid_q   <= 1'b0;
            res_taken_q   <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            br_cnt_q      <= '0;
            mis_cnt_q     <= '0;
        end else begin
            res_valid_q   <= res_valid_d;
            res_taken_q   <= res_taken_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            br_cnt_q      <= br_cnt_d;
            mis_cnt_q     <= mis_cnt_d;
        end
    end

    assign bus.if_pred_taken = pred_ctr[1];
    assign bus.res_valid     = res_valid_q;
    assign bus.res_taken     = res_taken_q;
    assign bus.redirect      = redirect_q;
    assign bus.redirect_pc   = redirect_pc_q;
    assign bus.br_count      = br_cnt_q;
    assign bus.mispred_count = mis_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and random checks of two DUTs (CNT_W=16 and CNT_W=2) against a behavioural model.
module tb_branch_resolve_unit;
    localparam int MAXA = 65535;
    localparam int MAXB = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] if_pc = '0;
    logic        ex_valid = 1'b0, ex_stall = 1'b0, ex_is_branch = 1'b0, ex_pred_taken = 1'b0;
    logic [2:0]  ex_br_mode = '0;
    logic [31:0] ex_rs = '0, ex_rt = '0, ex_pc = '0, ex_target = '0;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    int          bht [64];
    bit          e_valid, e_taken, e_redir;
    logic [31:0] e_rpc;
    int          e_br, e_mis, e_br2, e_mis2;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.WIDTH(32), .CNT_W(16)) ifa ();
    branch_resolve_unit_if #(.WIDTH(32), .CNT_W(2))  ifb ();

    assign ifa.if_pc = if_pc;            assign ifb.if_pc = if_pc;
    assign ifa.ex_valid = ex_valid;      assign ifb.ex_valid = ex_valid;
    assign ifa.ex_stall = ex_stall;      assign ifb.ex_stall = ex_stall;
    assign ifa.ex_is_branch = ex_is_branch;   assign ifb.ex_is_branch = ex_is_branch;
    assign ifa.ex_br_mode = ex_br_mode;  assign ifb.ex_br_mode = ex_br_mode;
    assign ifa.ex_rs = ex_rs;            assign ifb.ex_rs = ex_rs;
    assign ifa.ex_rt = ex_rt;            assign ifb.ex_rt = ex_rt;
    assign ifa.ex_pc = ex_pc;            assign ifb.ex_pc = ex_pc;
    assign ifa.ex_target = ex_target;    assign ifb.ex_target = ex_target;
    assign ifa.ex_pred_taken = ex_pred_taken; assign ifb.ex_pred_taken = ex_pred_taken;

    branch_resolve_unit #(.WIDTH(32), .BHT_DEPTH(64), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    branch_resolve_unit #(.WIDTH(32), .BHT_DEPTH(64), .CNT_W(2))  dut_b (.clk(clk), .reset(reset), .bus(ifb));

    function automatic bit model_taken(int mode, logic [31:0] rs, logic [31:0] rt);
        int s = int'($signed(rs));
        case (mode)
            0: return rs == rt;
            1: return rs != rt;
            2: return s <= 0;
            3: return s > 0;
            4: return s < 0;
            5: return s >= 0;
            default: return 0;
        endcase
    endfunction

    function automatic int pc_idx(logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    task automatic drive(bit v, bit st, bit br, int mode, logic [31:0] rs, logic [31:0] rt,
                         logic [31:0] pc, logic [31:0] tgt, bit pred);
        ex_valid = v; ex_stall = st; ex_is_branch = br; ex_br_mode = 3'(mode);
        ex_rs = rs; ex_rt = rt; ex_pc = pc; ex_target = tgt; ex_pred_taken = pred;
    endtask

    // Advance the model by one clock from the current inputs, then step the DUTs.
    task automatic tick();
        bit t, res;
        if (reset) begin
            foreach (bht[i]) bht[i] = 1;
            e_valid = 0; e_taken = 0; e_redir = 0; e_rpc = '0;
            e_br = 0; e_mis = 0; e_br2 = 0; e_mis2 = 0;
        end else begin
            res = ex_valid && !ex_stall && ex_is_branch && ex_br_mode < 6;
            t = model_taken(int'(ex_br_mode), ex_rs, ex_rt);
            e_valid = res;
            e_taken = res && t;
            e_redir = res && (t != ex_pred_taken);
            if (res) begin
                e_rpc = t ? ex_target : ex_pc + 32'd4;
                bht[pc_idx(ex_pc)] = t ? (bht[pc_idx(ex_pc)] < 3 ? bht[pc_idx(ex_pc)] + 1 : 3)
                                       : (bht[pc_idx(ex_pc)] > 0 ? bht[pc_idx(ex_pc)] - 1 : 0);
                e_br  = e_br  < MAXA ? e_br + 1  : e_br;
                e_br2 = e_br2 < MAXB ? e_br2 + 1 : e_br2;
                if (e_redir) begin
                    e_mis  = e_mis  < MAXA ? e_mis + 1  : e_mis;
                    e_mis2 = e_mis2 < MAXB ? e_mis2 + 1 : e_mis2;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        drive(1, 0, 1, 0, 9, 9, 32'h40, 32'h80, 0);
        tick();
        reset = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (ifa.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %0b exp 0", ifa.res_valid); end
        checks++; if (ifa.res_taken !== 1'b0) begin errors++; $display("FAIL reset_res_taken got %0b exp 0", ifa.res_taken); end
        checks++; if (ifa.redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got %0b exp 0", ifa.redirect); end
        checks++; if (ifa.redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc got %h exp 0", ifa.redirect_pc); end
        checks++; if (ifa.br_count !== 16'd0) begin errors++; $display("FAIL reset_br_count got %0d exp 0", ifa.br_count); end
        checks++; if (ifa.mispred_count !== 16'd0) begin errors++; $display("FAIL reset_mispred_count got %0d exp 0", ifa.mispred_count); end
        for (int k = 0; k < 8; k++) begin
            if_pc = $urandom;
            #1;
            checks++; if (ifa.if_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred pc=%h got %0b exp 0", if_pc, ifa.if_pred_taken); end
        end
    endtask

    task automatic test_beq();
        drive(1, 0, 1, 0, 5, 5, 32'h100, 32'h140, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (ifa.res_valid !== 1'b1) begin errors++; $display("FAIL beq_res_valid got %0b exp 1", ifa.res_valid); end
        checks++; if (ifa.res_taken !== 1'b1) begin errors++; $display("FAIL beq_res_taken got %0b exp 1", ifa.res_taken); end
        checks++; if (ifa.redirect !== 1'b1) begin errors++; $display("FAIL beq_redirect got %0b exp 1", ifa.redirect); end
        checks++; if (ifa.redirect_pc !== 32'h140) begin errors++; $display("FAIL beq_redirect_pc got %h exp 140", ifa.redirect_pc); end
        checks++; if (ifa.br_count !== 16'd1) begin errors++; $display("FAIL beq_br_count got %0d exp 1", ifa.br_count); end
        checks++; if (ifa.mispred_count !== 16'd1) begin errors++; $display("FAIL beq_mispred_count got %0d exp 1", ifa.mispred_count); end
        tick();
        checks++; if (ifa.redirect !== 1'b0) begin errors++; $display("FAIL beq_redirect_pulse got %0b exp 0", ifa.redirect); end
    endtask

    task automatic test_bne();
        do_reset();
        if_pc = 32'h200;
        drive(1, 0, 1, 1, 7, 7, 32'h200, 32'h999, 0);
        tick();
        checks++; if (ifa.res_taken !== 1'b0) begin errors++; $display("FAIL bne_res_taken got %0b exp 0", ifa.res_taken); end
        checks++; if (ifa.redirect !== 1'b0) begin errors++; $display("FAIL bne_redirect got %0b exp 0", ifa.redirect); end
        checks++; if (ifa.redirect_pc !== 32'h204) begin errors++; $display("FAIL bne_redirect_pc got %h exp 204", ifa.redirect_pc); end
        // Entry is now strong-NT: one taken leaves it predicting NT, a second flips it.
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 1, 0, 1, 1, 32'h200, 32'h280, 0);
            tick();
            checks++; if (ifa.if_pred_taken !== 1'(k)) begin errors++; $display("FAIL bne_bht_step%0d got %0b exp %0d", k, ifa.if_pred_taken, k); end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        if_pc = 32'h300;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (ifa.if_pred_taken !== 1'b0) begin errors++; $display("FAIL sat_pred_init got %0b exp 0", ifa.if_pred_taken); end
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 1, 0, 3, 3, 32'h300, 32'h310, 1);
            tick();
            checks++; if (ifa.if_pred_taken !== 1'b1) begin errors++; $display("FAIL sat_pred_taken%0d got %0b exp 1", k, ifa.if_pred_taken); end
        end
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 1, 1, 3, 3, 32'h300, 32'h310, 1);
            tick();
            checks++; if (ifa.if_pred_taken !== 1'(k == 0)) begin errors++; $display("FAIL sat_pred_down%0d got %0b exp %0d", k, ifa.if_pred_taken, k == 0); end
        end
    endtask

    task automatic test_signed();
        logic [31:0] rsv [2];
        bit          expt [2][4];
        rsv[0] = 32'hFFFF_FFFF; rsv[1] = 32'h0;
        expt[0] = '{1, 0, 1, 0};
        expt[1] = '{1, 0, 0, 1};
        for (int r = 0; r < 2; r++) begin
            for (int m = 2; m < 6; m++) begin
                drive(1, 0, 1, m, rsv[r], 32'h1234, 32'h600, 32'h700, 0);
                tick();
                checks++; if (ifa.res_taken !== expt[r][m-2]) begin errors++; $display("FAIL signed_taken rs=%h mode=%0d got %0b exp %0b", rsv[r], m, ifa.res_taken, expt[r][m-2]); end
                checks++; if (ifa.redirect_pc !== (expt[r][m-2] ? 32'h700 : 32'h604)) begin errors++; $display("FAIL signed_rpc rs=%h mode=%0d got %h", rsv[r], m, ifa.redirect_pc); end
            end
        end
    endtask

    task automatic test_bubbles();
        do_reset();
        drive(1, 0, 1, 0, 2, 3, 32'h500, 32'h900, 1);
        tick();
        if_pc = 32'h500;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) drive(1, 1, 1, 0, 4, 4, 32'h500, 32'h540, 0);
            else        drive(1, 0, 1, 6, 4, 4, 32'h500, 32'h540, 0);
            tick();
            checks++; if (ifa.res_valid !== 1'b0) begin errors++; $display("FAIL bubble%0d_res_valid got %0b exp 0", k, ifa.res_valid); end
            checks++; if (ifa.redirect !== 1'b0) begin errors++; $display("FAIL bubble%0d_redirect got %0b exp 0", k, ifa.redirect); end
            checks++; if (ifa.redirect_pc !== 32'h504) begin errors++; $display("FAIL bubble%0d_rpc got %h exp 504", k, ifa.redirect_pc); end
            checks++; if (ifa.br_count !== 16'd1 || ifa.mispred_count !== 16'd1) begin errors++; $display("FAIL bubble%0d_counts got %0d/%0d exp 1/1", k, ifa.br_count, ifa.mispred_count); end
        end
        // Entry is strong-NT after the not-taken branch above; an ignored update would not move it anyway, so step it up.
        drive(1, 0, 1, 0, 4, 4, 32'h500, 32'h540, 0);
        tick();
        drive(1, 0, 1, 0, 4, 4, 32'h500, 32'h540, 0);
        #1;
        checks++; if (ifa.if_pred_taken !== 1'b0) begin errors++; $display("FAIL same_index_old got %0b exp 0", ifa.if_pred_taken); end
        tick();
        checks++; if (ifa.if_pred_taken !== 1'b1) begin errors++; $display("FAIL same_index_new got %0b exp 1", ifa.if_pred_taken); end
    endtask

    task automatic test_random();
        logic [31:0] rs;
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 79) == 0);
            case ($urandom_range(0, 3))
                0: rs = 32'h0;
                1: rs = 32'hFFFF_FFFF;
                2: rs = 32'($urandom_range(0, 3));
                default: rs = $urandom;
            endcase
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) != 0,
                  int'($urandom_range(0, 7)), rs, $urandom_range(0, 1) ? rs : $urandom,
                  {24'h0, 6'($urandom), 2'b00}, $urandom, $urandom_range(0, 1));
            if_pc = {24'h0, 6'($urandom), 2'b00};
            #1;
            checks++; if (ifa.if_pred_taken !== (bht[pc_idx(if_pc)] >= 2)) begin errors++; $display("FAIL rnd_pred n=%0d got %0b exp %0b", n, ifa.if_pred_taken, bht[pc_idx(if_pc)] >= 2); end
            tick();
            checks++;
            if (ifa.res_valid !== e_valid || ifa.res_taken !== e_taken || ifa.redirect !== e_redir || ifa.redirect_pc !== e_rpc) begin
                errors++;
                $display("FAIL rnd_outputs n=%0d got v%0b t%0b r%0b pc=%h exp v%0b t%0b r%0b pc=%h", n,
                         ifa.res_valid, ifa.res_taken, ifa.redirect, ifa.redirect_pc, e_valid, e_taken, e_redir, e_rpc);
            end
            checks++;
            if (int'(ifa.br_count) != e_br || int'(ifa.mispred_count) != e_mis || int'(ifb.br_count) != e_br2 || int'(ifb.mispred_count) != e_mis2) begin
                errors++;
                $display("FAIL rnd_counts n=%0d got %0d/%0d %0d/%0d exp %0d/%0d %0d/%0d", n, ifa.br_count, ifa.mispred_count,
                         ifb.br_count, ifb.mispred_count, e_br, e_mis, e_br2, e_mis2);
            end
        end
        reset = 0;
    endtask

    task automatic test_cnt_sat();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 1, 0, 8, 8, 32'h1000 + 32'(k * 4), 32'h2000, 0);
            tick();
            checks++; if (int'(ifb.mispred_count) != (k + 1 < 3 ? k + 1 : 3)) begin errors++; $display("FAIL cnt2_mispred k=%0d got %0d", k, ifb.mispred_count); end
        end
        checks++; if (ifa.mispred_count !== 16'd5 || ifb.br_count !== 2'd3) begin errors++; $display("FAIL cnt_final got %0d/%0d exp 5/3", ifa.mispred_count, ifb.br_count); end
        reset = 1;
        drive(1, 0, 1, 0, 8, 8, 32'h1000, 32'h2000, 0);
        tick();
        reset = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ifa.res_valid !== 0 || ifa.redirect !== 0 || ifa.redirect_pc !== 0 || ifa.br_count !== 0 || ifa.mispred_count !== 0 ||
            ifb.br_count !== 0 || ifb.mispred_count !== 0) begin
            errors++;
            $display("FAIL midreset_outputs got v%0b r%0b pc=%h %0d/%0d %0d/%0d exp all 0", ifa.res_valid, ifa.redirect,
                     ifa.redirect_pc, ifa.br_count, ifa.mispred_count, ifb.br_count, ifb.mispred_count);
        end
        for (int i = 0; i < 64; i++) begin
            if_pc = 32'(i * 4);
            #1;
            checks++; if (ifa.if_pred_taken !== 1'b0) begin errors++; $display("FAIL midreset_pred idx=%0d got %0b exp 0", i, ifa.if_pred_taken); end
        end
        // One taken update from weak-NT must flip the prediction.
        if_pc = 32'h1004;
        drive(1, 0, 1, 0, 8, 8, 32'h1004, 32'h2000, 0);
        tick();
        checks++; if (ifa.if_pred_taken !== 1'b1) begin errors++; $display("FAIL midreset_wnt got %0b exp 1", ifa.if_pred_taken); end
    endtask

    initial begin
        foreach (bht[i]) bht[i] = 1;
        test_reset();
        test_beq();
        test_bne();
        test_saturate();
        test_signed();
        test_bubbles();
        test_random();
        test_cnt_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
